clockdivide_var: RTL and testbench

- Parametrised, glitch-free programmable clock divider.
- Successor to the fixed 8-bit divider: configurable counter width, selectable output mode (50% duty or single-cycle pulse), divisor changes applied only at period boundaries, and a clean start/stop sequence.
- Drives CPLD-side peripheral clocks (e.g. SPI/serial bit clocks) from the system clock.
- Also provides a synchronous tick strobe for logic in the clk domain.

---
 rtl/clockdivide_var.sv | 126 ++++++++++++
 tb/tb_clockdivide_var.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clockdivide_var.sv
// Programmable glitch-free clock divider: 50% or single-pulse output, divisor
// reloaded only at period boundaries, drain-to-boundary stop, clk-domain tick.
module clockdivide_var #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div,
    input  logic             mode,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);
    localparam int unsigned HW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] cur_div, cur_div_d;
    logic             cur_mode, cur_mode_d;
    logic             q_pos, q_pos_d;
    logic             q_neg;
    logic             run_gate;
    logic             byp_q, byp_q_d;
    logic             odd_q, odd_q_d;
    logic             tick_d, active_d;
    logic             bypass, wrap, load;
    logic [HW-1:0]    half;

    // Next-state, counter, boundary reload and registered-output decode
    always_comb begin
        state_d    = state;
        cur_div_d  = cur_div;
        cur_mode_d = cur_mode;
        load       = 1'b0;

        bypass = (cur_div < WIDTH'(2));
        wrap   = bypass || (cnt == (cur_div - WIDTH'(1)));
        half   = (HW'(cur_div) + HW'(1)) >> 1;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (enable) load = 1'b1;
                    else        state_d = IDLE;
                end else if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                    load    = wrap;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = ((state == IDLE) || wrap) ? '0 : (cnt + WIDTH'(1));
        if (load) begin
            cur_div_d  = div;
            cur_mode_d = mode;
        end

        // Output-side flags lag the counter by one cycle, so the bypass and
        // odd-duty selects travel with the period actually being emitted.
        q_pos_d  = (state != IDLE) && !bypass &&
                   (cur_mode ? (cnt == '0) : (HW'(cnt) < half));
        tick_d   = (state != IDLE) && (cnt == '0);
        byp_q_d  = (state != IDLE) && bypass;
        odd_q_d  = cur_div[0] && !cur_mode && !bypass;
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_div  <= '0;
            cur_mode <= 1'b0;
            q_pos    <= 1'b0;
            tick     <= 1'b0;
            active   <= 1'b0;
            byp_q    <= 1'b0;
            odd_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cur_div  <= cur_div_d;
            cur_mode <= cur_mode_d;
            q_pos    <= q_pos_d;
            tick     <= tick_d;
            active   <= active_d;
            byp_q    <= byp_q_d;
            odd_q    <= odd_q_d;
        end
    end

    // Half-cycle flops: odd-divisor duty correction and bypass clock gate
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            q_neg    <= 1'b0;
            run_gate <= 1'b0;
        end else begin
            q_neg    <= q_pos;
            run_gate <= (state != IDLE);
        end
    end

    assign clk_out = byp_q ? (clk & run_gate) : (q_pos & (odd_q ? q_neg : 1'b1));

endmodule

// File: tb/tb_clockdivide_var.sv
// Self-checking bench for clockdivide_var: period-level reference model
// compared per half-cycle, plus a WIDTH=4 instance for the long odd period.
module tb_clockdivide_var;
    localparam int unsigned W    = 8;
    localparam int          MAXC = 8192;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         enable = 1'b0;
    logic         mode   = 1'b0;
    logic [W-1:0] div    = '0;
    logic         clk_out, tick, active;

    logic         en4   = 1'b0;
    logic [3:0]   div4  = 4'd15;
    logic         mode4 = 1'b0;
    logic         clk_out4, tick4, active4;

    clockdivide_var #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .div(div), .mode(mode),
        .clk_out(clk_out), .tick(tick), .active(active)
    );

    clockdivide_var #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .enable(en4), .div(div4), .mode(mode4),
        .clk_out(clk_out4), .tick(tick4), .active(active4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected values per clk cycle (cycle c = interval after posedge number c)
    bit eh1 [MAXC];
    bit eh2 [MAXC];
    bit etk [MAXC];
    bit eact[MAXC];
    int cyc      = 0;
    int now_c    = 0;
    bit busy     = 1'b0;
    int end_edge = 0;

    // A period started at edge c emits its waveform over cycles c+1..c+N and
    // keeps active high over cycles c..c+N-1. Odd 50% periods are high for N
    // half-cycles beginning half a cycle late; even ones for the first N/2 cycles.
    task automatic model_start(input int c, input int dv, input bit md);
        int n, lo, hi, j0;
        n  = (dv < 2) ? 1 : dv;
        lo = (n % 2 == 1) ? 1 : 0;
        hi = (n % 2 == 1) ? n : n - 1;
        for (int k = 1; k <= n; k++) begin
            j0 = 2 * (k - 1);
            if (dv < 2) begin
                eh1[c+k] = 1'b1;
                eh2[c+k] = 1'b0;
            end else if (md) begin
                eh1[c+k] = (k == 1);
                eh2[c+k] = (k == 1);
            end else begin
                eh1[c+k] = (j0 >= lo) && (j0 <= hi);
                eh2[c+k] = (j0 + 1 >= lo) && (j0 + 1 <= hi);
            end
            etk[c+k] = (k == 1);
        end
        for (int k = 0; k < n; k++) eact[c+k] = 1'b1;
        busy     = 1'b1;
        end_edge = c + n;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            now_c = cyc;
            if (!reset) begin
                busy = 1'b0;
                for (int k = 0; k < 300; k++) begin
                    if (now_c + k < MAXC) begin
                        eh1[now_c+k]  = 1'b0;
                        eh2[now_c+k]  = 1'b0;
                        etk[now_c+k]  = 1'b0;
                        eact[now_c+k] = 1'b0;
                    end
                end
            end else if (!busy || now_c == end_edge) begin
                if (enable) model_start(now_c, int'(div), mode);
                else        busy = 1'b0;
            end
            cyc = cyc + 1;
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        #2;
        reset = 1'b0;
        #1;
        obs = {clk_out, tick, active};
        n_cmp++;
        if (obs !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_async got=%b exp=000", obs);
        end
        enable = 1'b1;
        div    = W'(4);
        @(posedge clk);
        #1;
        obs = {clk_out, tick, active};
        n_cmp++;
        if (obs !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_hold_pos got=%b exp=000", obs);
        end
        @(negedge clk);
        #1;
        obs = {clk_out4, tick4, active4};
        n_cmp++;
        if (obs !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_w4 got=%b exp=000", obs);
        end
        enable = 1'b0;
        reset  = 1'b1;
    endtask

    task automatic test_even();
        logic [3:0] obs, expv;
        do_reset();
        div = W'(4); mode = 1'b0; enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1; obs[3:1] = {clk_out, tick, active};
            @(negedge clk); #1; obs[0] = clk_out;
            expv = {eh1[now_c], etk[now_c], eact[now_c], eh2[now_c]};
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL even cyc=%0d got=%b exp=%b", now_c, obs, expv);
            end
        end
    endtask

    task automatic test_odd();
        logic [3:0] obs, expv;
        do_reset();
        div = W'(5); mode = 1'b0; enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1; obs[3:1] = {clk_out, tick, active};
            @(negedge clk); #1; obs[0] = clk_out;
            expv = {eh1[now_c], etk[now_c], eact[now_c], eh2[now_c]};
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL odd cyc=%0d got=%b exp=%b", now_c, obs, expv);
            end
            if (i == 12) div = W'(3);
        end
    endtask

    task automatic test_pulse_boundary();
        logic [3:0] obs, expv;
        do_reset();
        div = W'(6); mode = 1'b1; enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1; obs[3:1] = {clk_out, tick, active};
            @(negedge clk); #1; obs[0] = clk_out;
            expv = {eh1[now_c], etk[now_c], eact[now_c], eh2[now_c]};
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL pulse cyc=%0d got=%b exp=%b", now_c, obs, expv);
            end
            if (i == 2) div = W'(3);
        end
    endtask

    task automatic test_drain();
        logic [3:0] obs, expv;
        do_reset();
        div = W'(8); mode = 1'b0; enable = 1'b1;
        for (int i = 0; i < 28; i++) begin
            @(posedge clk); #1; obs[3:1] = {clk_out, tick, active};
            @(negedge clk); #1; obs[0] = clk_out;
            expv = {eh1[now_c], etk[now_c], eact[now_c], eh2[now_c]};
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL drain cyc=%0d got=%b exp=%b", now_c, obs, expv);
            end
            if (i == 3)  enable = 1'b0;
            if (i == 5)  enable = 1'b1;
            if (i == 12) enable = 1'b0;
        end
    endtask

    task automatic test_bypass();
        logic [3:0] obs, expv;
        do_reset();
        div = W'(1); mode = 1'b0; enable = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1; obs[3:1] = {clk_out, tick, active};
            @(negedge clk); #1; obs[0] = clk_out;
            expv = {eh1[now_c], etk[now_c], eact[now_c], eh2[now_c]};
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL bypass cyc=%0d got=%b exp=%b", now_c, obs, expv);
            end
            if (i == 8)  enable = 1'b0;
            if (i == 11) begin div = W'(0); mode = 1'b1; enable = 1'b1; end
            if (i == 19) enable = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, expv;
        logic [2:0] now3;
        do_reset();
        div = W'(7); mode = 1'b0; enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1; obs[3:1] = {clk_out, tick, active};
            @(negedge clk); #1; obs[0] = clk_out;
            expv = {eh1[now_c], etk[now_c], eact[now_c], eh2[now_c]};
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL rmid_pre cyc=%0d got=%b exp=%b", now_c, obs, expv);
            end
        end
        reset = 1'b0;
        #1;
        now3 = {clk_out, tick, active};
        n_cmp++;
        if (now3 !== 3'b000) begin
            n_bad++;
            $display("FAIL rmid_async got=%b exp=000", now3);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1; obs[3:1] = {clk_out, tick, active};
            @(negedge clk); #1; obs[0] = clk_out;
            expv = {eh1[now_c], etk[now_c], eact[now_c], eh2[now_c]};
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL rmid_post cyc=%0d got=%b exp=%b", now_c, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] obs, expv;
        bit         rel;
        do_reset();
        div = W'(3); mode = 1'b0; enable = 1'b1; rel = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1; obs[3:1] = {clk_out, tick, active};
            @(negedge clk); #1; obs[0] = clk_out;
            expv = {eh1[now_c], etk[now_c], eact[now_c], eh2[now_c]};
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL random cyc=%0d div=%0d mode=%0b got=%b exp=%b",
                         now_c, div, mode, obs, expv);
            end
            if (rel) begin
                reset = 1'b1;
                rel   = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                rel   = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 5) == 0) div = W'($urandom_range(13, 40));
                else                           div = W'($urandom_range(0, 12));
                mode = 1'($urandom_range(0, 1));
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_width4();
        logic prev, cur, s29;
        bit   found;
        int   h, hi_cnt;
        do_reset();
        enable = 1'b0;
        en4    = 1'b1;
        div4   = 4'd15;
        prev = 1'b0; found = 1'b0; h = 0;
        while (!found && h < 80) begin
            if (h % 2 == 0) @(posedge clk); else @(negedge clk);
            #1;
            cur = clk_out4;
            if (!prev && cur) found = 1'b1;
            prev = cur;
            h++;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL w4_rise got=none exp=rise within 40 cycles");
        end
        n_cmp++;
        if ({tick4, active4} !== 2'b11) begin
            n_bad++;
            $display("FAIL w4_tick_active got=%b exp=11", {tick4, active4});
        end
        hi_cnt = 1;
        s29    = 1'b1;
        for (int s = 1; s < 30; s++) begin
            if (h % 2 == 0) @(posedge clk); else @(negedge clk);
            #1;
            h++;
            if (clk_out4) hi_cnt++;
            if (s == 29) s29 = clk_out4;
        end
        n_cmp++;
        if (hi_cnt != 15) begin
            n_bad++;
            $display("FAIL w4_high_halves got=%0d exp=15", hi_cnt);
        end
        n_cmp++;
        if (s29 !== 1'b0) begin
            n_bad++;
            $display("FAIL w4_low_before_rise got=%b exp=0", s29);
        end
        if (h % 2 == 0) @(posedge clk); else @(negedge clk);
        #1;
        n_cmp++;
        if (clk_out4 !== 1'b1) begin
            n_bad++;
            $display("FAIL w4_period got=%b exp=1 at 15 cycles", clk_out4);
        end
        en4 = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd();
        test_pulse_boundary();
        test_drain();
        test_bypass();
        test_reset_mid();
        test_random();
        test_width4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
